plate_op_arbiter: RTL and testbench

Arbiter and sequencer for the game plate opcode port. It collects move requests from three sources: system sequence steps (commit, check, new), gravity ticks and user moves. It grants one request at a time by fixed priority and drives the plate's valid/ready/done/yumi handshake for that request. It reports each completion back to the game controller, so the controller no longer drives the plate directly.

---
 rtl/plate_op_arbiter_if.sv | 12 +
 rtl/plate_op_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_plate_op_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/plate_op_arbiter_if.sv
// Plate opcode port: the arbiter drives opcode/valid/yumi, the plate answers
// with ready (opcode accepted) and done (op finished, held until yumi).
interface plate_op_arbiter_if;
    logic [2:0] opcode;
    logic       opcode_v;
    logic       ready;
    logic       done;
    logic       yumi;

    modport master (output opcode, opcode_v, yumi, input ready, done);
    modport slave  (input opcode, opcode_v, yumi, output ready, done);
endinterface

// File: rtl/plate_op_arbiter.sv
// Collects system, gravity and user move requests, grants one at a time by
// fixed priority (sys > gravity > user) and sequences the plate handshake
// IDLE -> ISSUE -> WAIT -> ACK, reporting each completion with its source.
module plate_op_arbiter #(
    parameter int max_drops_p = 3,
    parameter int timeout_p   = 1023
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       flush_i,
    input  logic                       sys_v_i,
    input  logic [1:0]                 sys_op_i,
    output logic                       sys_ready_o,
    input  logic                       tick_i,
    input  logic                       user_v_i,
    input  logic [1:0]                 user_op_i,
    output logic                       user_ready_o,
    plate_op_arbiter_if.master         plate,
    output logic                       done_o,
    output logic [1:0]                 done_src_o,
    output logic                       busy_o,
    output logic                       overflow_o,
    output logic                       error_o
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;
    typedef enum logic [2:0] {
        eNop, eMoveLeft, eMoveRight, eRotate, eMoveDown, eCommit, eCheck, eNew
    } opcode_e;

    localparam logic [1:0] SRC_SYS  = 2'd0;
    localparam logic [1:0] SRC_GRAV = 2'd1;
    localparam logic [1:0] SRC_USER = 2'd2;
    localparam logic [2:0] MAX_DROPS = 3'(max_drops_p);
    localparam int         CNT_W = $clog2(timeout_p + 1);
    // Last WAIT cycle before abort; the abort edge brings the count to timeout_p.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(timeout_p - 1);

    state_e           state_r;
    opcode_e          opc_r;
    logic             opc_v_r;
    logic [1:0]       src_r;
    logic             yumi_r;
    logic             done_r;
    logic [1:0]       done_src_r;
    logic             busy_r;
    logic             error_r;
    logic [CNT_W-1:0] wait_cnt_r;

    logic             sys_full_r;
    opcode_e          sys_opc_r;
    logic             user_full_r;
    opcode_e          user_opc_r;
    logic [2:0]       drops_r;
    logic             overflow_r;

    logic             sys_acc, sys_illegal, user_acc;
    logic             idle_grant, grant_sys, grant_grav, grant_user, grant_any;
    opcode_e          grant_op;
    logic [1:0]       grant_src;

    // Acceptance and fixed-priority grant; no grant while a flush is clearing the holders.
    always_comb begin
        sys_acc     = sys_v_i && !sys_full_r;
        sys_illegal = sys_acc && (sys_op_i == 2'd3);
        user_acc    = user_v_i && !user_full_r && (user_op_i != 2'd0);
        idle_grant  = (state_r == S_IDLE) && !flush_i;
        grant_sys   = idle_grant && sys_full_r;
        grant_grav  = idle_grant && !sys_full_r && (drops_r != 3'd0);
        grant_user  = idle_grant && !sys_full_r && (drops_r == 3'd0) && user_full_r;
        grant_any   = grant_sys || grant_grav || grant_user;
        grant_op    = eNop;
        grant_src   = SRC_SYS;
        if (grant_sys) begin
            grant_op  = sys_opc_r;
            grant_src = SRC_SYS;
        end else if (grant_grav) begin
            grant_op  = eMoveDown;
            grant_src = SRC_GRAV;
        end else if (grant_user) begin
            grant_op  = user_opc_r;
            grant_src = SRC_USER;
        end
    end

    // Request holders: two 1-entry buffers and the saturating drop counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sys_full_r  <= 1'b0;
            sys_opc_r   <= eNop;
            user_full_r <= 1'b0;
            user_opc_r  <= eNop;
            drops_r     <= 3'd0;
            overflow_r  <= 1'b0;
        end else if (flush_i) begin
            sys_full_r  <= 1'b0;
            user_full_r <= 1'b0;
            drops_r     <= 3'd0;
        end else begin
            if (grant_sys) begin
                sys_full_r <= 1'b0;
            end else if (sys_acc && !sys_illegal) begin
                sys_full_r <= 1'b1;
                sys_opc_r  <= opcode_e'(3'd5 + {1'b0, sys_op_i});
            end
            if (grant_user) begin
                user_full_r <= 1'b0;
            end else if (user_acc) begin
                user_full_r <= 1'b1;
                user_opc_r  <= opcode_e'({1'b0, user_op_i});
            end
            // A tick that coincides with a grant decrement cancels it, even at saturation.
            case ({tick_i, grant_grav})
                2'b10: begin
                    if (drops_r == MAX_DROPS) overflow_r <= 1'b1;
                    else                      drops_r    <= drops_r + 3'd1;
                end
                2'b01:   drops_r <= drops_r - 3'd1;
                default: ;
            endcase
        end
    end

    // Handshake FSM; every plate-facing and status output is a register set on transitions.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= S_IDLE;
            opc_r      <= eNop;
            opc_v_r    <= 1'b0;
            src_r      <= SRC_SYS;
            yumi_r     <= 1'b0;
            done_r     <= 1'b0;
            done_src_r <= SRC_SYS;
            busy_r     <= 1'b0;
            error_r    <= 1'b0;
            wait_cnt_r <= '0;
        end else begin
            yumi_r     <= 1'b0;
            done_r     <= 1'b0;
            done_src_r <= SRC_SYS;
            if (sys_illegal) error_r <= 1'b1;
            case (state_r)
                S_IDLE: begin
                    if (grant_any) begin
                        state_r <= S_ISSUE;
                        opc_r   <= grant_op;
                        opc_v_r <= 1'b1;
                        src_r   <= grant_src;
                        busy_r  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // A transfer on this edge has already happened, so ready wins over flush.
                    if (plate.ready) begin
                        state_r    <= S_WAIT;
                        opc_r      <= eNop;
                        opc_v_r    <= 1'b0;
                        wait_cnt_r <= '0;
                    end else if (flush_i) begin
                        state_r <= S_IDLE;
                        opc_r   <= eNop;
                        opc_v_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + 1'b1;
                    if (plate.done) begin
                        state_r    <= S_ACK;
                        yumi_r     <= 1'b1;
                        done_r     <= 1'b1;
                        done_src_r <= src_r;
                    end else if (wait_cnt_r == TO_LAST) begin
                        state_r <= S_IDLE;
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                S_ACK: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign plate.opcode   = opc_r;
    assign plate.opcode_v = opc_v_r;
    assign plate.yumi     = yumi_r;
    assign sys_ready_o    = !sys_full_r;
    assign user_ready_o   = !user_full_r;
    assign done_o         = done_r;
    assign done_src_o     = done_src_r;
    assign busy_o         = busy_r;
    assign overflow_o     = overflow_r;
    assign error_o        = error_r;
endmodule

// File: tb/tb_plate_op_arbiter.sv
// Directed bench for plate_op_arbiter (max_drops_p=3, timeout_p=8).
module tb_plate_op_arbiter;
    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       sys_v_i = 1'b0;
    logic [1:0] sys_op_i = 2'd0;
    logic       sys_ready_o;
    logic       tick_i = 1'b0;
    logic       user_v_i = 1'b0;
    logic [1:0] user_op_i = 2'd0;
    logic       user_ready_o;
    logic       done_o;
    logic [1:0] done_src_o;
    logic       busy_o, overflow_o, error_o;

    int checks = 0;
    int errors = 0;
    logic [2:0] ops_q[$];
    logic [1:0] srcs_q[$];

    plate_op_arbiter_if plate_bus();

    plate_op_arbiter #(.max_drops_p(3), .timeout_p(8)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
        .sys_v_i(sys_v_i), .sys_op_i(sys_op_i), .sys_ready_o(sys_ready_o),
        .tick_i(tick_i), .user_v_i(user_v_i), .user_op_i(user_op_i),
        .user_ready_o(user_ready_o), .plate(plate_bus), .done_o(done_o),
        .done_src_o(done_src_o), .busy_o(busy_o), .overflow_o(overflow_o),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    // Records transferred opcodes and completion sources, one sample per cycle.
    task automatic collect(input int n);
        repeat (n) begin
            if (plate_bus.opcode_v && plate_bus.ready) ops_q.push_back(plate_bus.opcode);
            if (done_o) srcs_q.push_back(done_src_o);
            step();
        end
    endtask

    task automatic test_reset();
        plate_bus.ready = 1'b0; plate_bus.done = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if ({plate_bus.opcode, plate_bus.opcode_v, plate_bus.yumi} !== 5'b0) begin errors++; $display("FAIL reset_plate: got %b expected 00000", {plate_bus.opcode, plate_bus.opcode_v, plate_bus.yumi}); end
        checks++; if ({done_o, done_src_o, busy_o, overflow_o, error_o} !== 6'b0) begin errors++; $display("FAIL reset_status: got %b expected 000000", {done_o, done_src_o, busy_o, overflow_o, error_o}); end
        checks++; if ({sys_ready_o, user_ready_o} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b expected 11", {sys_ready_o, user_ready_o}); end
        @(negedge clk_i); reset_n_i = 1'b1;
        step();
    endtask

    task automatic test_round_trip();
        plate_bus.ready = 1'b1; plate_bus.done = 1'b1;
        user_v_i = 1'b1; user_op_i = 2'd1;
        step();
        user_v_i = 1'b0; user_op_i = 2'd0;
        checks++; if ({user_ready_o, busy_o} !== 2'b00) begin errors++; $display("FAIL rt_capture: got %b expected 00", {user_ready_o, busy_o}); end
        step();
        checks++; if ({plate_bus.opcode_v, plate_bus.opcode, busy_o, user_ready_o} !== 6'b1_001_1_1) begin errors++; $display("FAIL rt_issue: got %b expected 100111", {plate_bus.opcode_v, plate_bus.opcode, busy_o, user_ready_o}); end
        step();
        checks++; if ({plate_bus.opcode_v, plate_bus.opcode, done_o} !== 5'b0) begin errors++; $display("FAIL rt_wait: got %b expected 00000", {plate_bus.opcode_v, plate_bus.opcode, done_o}); end
        step();
        checks++; if ({done_o, plate_bus.yumi, done_src_o} !== 4'b11_10) begin errors++; $display("FAIL rt_ack: got %b expected 1110", {done_o, plate_bus.yumi, done_src_o}); end
        step();
        checks++; if ({done_o, plate_bus.yumi, busy_o} !== 3'b000) begin errors++; $display("FAIL rt_idle: got %b expected 000", {done_o, plate_bus.yumi, busy_o}); end
    endtask

    task automatic test_priority();
        logic [2:0] exp_op[4];
        logic [1:0] exp_src[4];
        exp_op  = '{3'd7, 3'd4, 3'd4, 3'd3};
        exp_src = '{2'd0, 2'd1, 2'd1, 2'd2};
        ops_q.delete(); srcs_q.delete();
        plate_bus.ready = 1'b1; plate_bus.done = 1'b1;
        sys_v_i = 1'b1; sys_op_i = 2'd2; user_v_i = 1'b1; user_op_i = 2'd3; tick_i = 1'b1;
        step();
        sys_v_i = 1'b0; sys_op_i = 2'd0; user_v_i = 1'b0; user_op_i = 2'd0;
        step();
        tick_i = 1'b0;
        collect(24);
        checks++; if (ops_q.size() != 4 || srcs_q.size() != 4) begin errors++; $display("FAIL prio_count: got %0d ops %0d dones expected 4 4", ops_q.size(), srcs_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (ops_q[i] !== exp_op[i]) begin errors++; $display("FAIL prio_op[%0d]: got %0d expected %0d", i, ops_q[i], exp_op[i]); end
                checks++; if (srcs_q[i] !== exp_src[i]) begin errors++; $display("FAIL prio_src[%0d]: got %0d expected %0d", i, srcs_q[i], exp_src[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        plate_bus.ready = 1'b0; plate_bus.done = 1'b0;
        sys_v_i = 1'b1; sys_op_i = 2'd1;
        step();
        sys_v_i = 1'b0; sys_op_i = 2'd0;
        step();
        for (int i = 0; i < 10; i++) begin
            checks++; if ({plate_bus.opcode_v, plate_bus.opcode} !== 4'b1_110) begin errors++; $display("FAIL bp_hold[%0d]: got %b expected 1110", i, {plate_bus.opcode_v, plate_bus.opcode}); end
            step();
        end
        plate_bus.ready = 1'b1;
        step();
        plate_bus.ready = 1'b0;
        checks++; if ({plate_bus.opcode_v, busy_o, done_o} !== 3'b010) begin errors++; $display("FAIL bp_wait: got %b expected 010", {plate_bus.opcode_v, busy_o, done_o}); end
        plate_bus.done = 1'b1;
        step();
        checks++; if ({done_o, done_src_o} !== 3'b1_00) begin errors++; $display("FAIL bp_ack: got %b expected 100", {done_o, done_src_o}); end
        plate_bus.done = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        logic [2:0] exp_op[4];
        exp_op = '{3'd2, 3'd4, 3'd4, 3'd4};
        ops_q.delete(); srcs_q.delete();
        plate_bus.ready = 1'b0; plate_bus.done = 1'b1;
        user_v_i = 1'b1; user_op_i = 2'd2;
        step();
        user_v_i = 1'b0; user_op_i = 2'd0;
        step();
        tick_i = 1'b1;
        repeat (3) step();
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL sat_ovf_3: got %b expected 0", overflow_o); end
        step();
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL sat_ovf_4: got %b expected 1", overflow_o); end
        step();
        tick_i = 1'b0;
        plate_bus.ready = 1'b1;
        collect(24);
        checks++; if (ops_q.size() != 4) begin errors++; $display("FAIL sat_count: got %0d expected 4", ops_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (ops_q[i] !== exp_op[i]) begin errors++; $display("FAIL sat_op[%0d]: got %0d expected %0d", i, ops_q[i], exp_op[i]); end
            end
        end
    endtask

    task automatic test_flush();
        ops_q.delete(); srcs_q.delete();
        plate_bus.ready = 1'b0; plate_bus.done = 1'b0;
        sys_v_i = 1'b1; sys_op_i = 2'd0; user_v_i = 1'b1; user_op_i = 2'd1; tick_i = 1'b1;
        step();
        sys_v_i = 1'b0; user_v_i = 1'b0; user_op_i = 2'd0; tick_i = 1'b0;
        step();
        checks++; if ({plate_bus.opcode_v, plate_bus.opcode} !== 4'b1_101) begin errors++; $display("FAIL fl_issue: got %b expected 1101", {plate_bus.opcode_v, plate_bus.opcode}); end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks++; if ({plate_bus.opcode_v, plate_bus.opcode, busy_o, user_ready_o} !== 6'b0_000_0_1) begin errors++; $display("FAIL fl_withdraw: got %b expected 000001", {plate_bus.opcode_v, plate_bus.opcode, busy_o, user_ready_o}); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL fl_sticky: got %b expected 1", overflow_o); end
        plate_bus.ready = 1'b1; plate_bus.done = 1'b1;
        collect(8);
        checks++; if (ops_q.size() != 0) begin errors++; $display("FAIL fl_cleared: got %0d ops expected 0", ops_q.size()); end
        plate_bus.done = 1'b0;
        user_v_i = 1'b1; user_op_i = 2'd2;
        step();
        user_v_i = 1'b0; user_op_i = 2'd0;
        step();
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; plate_bus.done = 1'b1;
        step();
        checks++; if ({done_o, done_src_o} !== 3'b1_10) begin errors++; $display("FAIL fl_wait_done: got %b expected 110", {done_o, done_src_o}); end
        plate_bus.done = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int seen_done = 0;
        plate_bus.ready = 1'b1; plate_bus.done = 1'b0;
        user_v_i = 1'b1; user_op_i = 2'd3;
        step();
        user_v_i = 1'b0; user_op_i = 2'd0;
        step();
        step();
        checks++; if ({busy_o, plate_bus.opcode_v, error_o} !== 3'b100) begin errors++; $display("FAIL to_entry: got %b expected 100", {busy_o, plate_bus.opcode_v, error_o}); end
        for (int k = 1; k < 8; k++) begin
            step();
            if (done_o) seen_done++;
            checks++; if ({error_o, busy_o} !== 2'b01) begin errors++; $display("FAIL to_wait[%0d]: got %b expected 01", k, {error_o, busy_o}); end
        end
        step();
        if (done_o) seen_done++;
        checks++; if ({error_o, busy_o} !== 2'b10) begin errors++; $display("FAIL to_abort: got %b expected 10", {error_o, busy_o}); end
        step();
        if (done_o) seen_done++;
        checks++; if (seen_done != 0) begin errors++; $display("FAIL to_no_done: got %0d expected 0", seen_done); end
    endtask

    task automatic test_reset_mid_issue();
        plate_bus.ready = 1'b0; plate_bus.done = 1'b0;
        user_v_i = 1'b1; user_op_i = 2'd1;
        step();
        user_v_i = 1'b0; user_op_i = 2'd0;
        step();
        checks++; if (plate_bus.opcode_v !== 1'b1) begin errors++; $display("FAIL rmi_issue: got %b expected 1", plate_bus.opcode_v); end
        #3 reset_n_i = 1'b0;
        #1;
        checks++; if ({plate_bus.opcode_v, plate_bus.opcode, busy_o, user_ready_o, error_o, overflow_o} !== 8'b0_000_0_1_0_0) begin errors++; $display("FAIL rmi_async: got %b expected 00000100", {plate_bus.opcode_v, plate_bus.opcode, busy_o, user_ready_o, error_o, overflow_o}); end
        @(negedge clk_i); reset_n_i = 1'b1;
        plate_bus.ready = 1'b1; plate_bus.done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if ({plate_bus.yumi, plate_bus.opcode_v, done_o} !== 3'b000) begin errors++; $display("FAIL rmi_quiet[%0d]: got %b expected 000", i, {plate_bus.yumi, plate_bus.opcode_v, done_o}); end
        end
        plate_bus.done = 1'b0;
    endtask

    task automatic test_illegal();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL ill_pre: got %b expected 0", error_o); end
        sys_v_i = 1'b1; sys_op_i = 2'd3;
        step();
        sys_v_i = 1'b0; sys_op_i = 2'd0;
        checks++; if ({error_o, sys_ready_o, busy_o} !== 3'b110) begin errors++; $display("FAIL ill_accept: got %b expected 110", {error_o, sys_ready_o, busy_o}); end
        step();
        checks++; if ({busy_o, plate_bus.opcode_v} !== 2'b00) begin errors++; $display("FAIL ill_no_grant: got %b expected 00", {busy_o, plate_bus.opcode_v}); end
    endtask

    initial begin
        plate_bus.ready = 1'b0;
        plate_bus.done  = 1'b0;
        test_reset();
        test_round_trip();
        test_priority();
        test_backpressure();
        test_saturation();
        test_flush();
        test_timeout();
        test_reset_mid_issue();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
